// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed 8-digit seven-segment scan controller with once-per-frame shadow capture.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module sseg_scan_ctrl #(
    parameter int CLK_DIV_BITS = 17,
    parameter int N_DIGITS     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        freeze,
    input  logic [31:0] hexs,
    input  logic [7:0]  points,
    input  logic [7:0]  LEs,
    output logic [3:0]  D,
    output logic        point,
    output logic        LE,
    output logic [7:0]  AN,
    output logic        frame_done
);

    localparam logic [2:0] LAST_IDX = 3'(N_DIGITS - 1);
    // Anode bits belonging to real digits; the rest are forced dark.
    localparam logic [7:0] USED_AN  = 8'((16'd1 << N_DIGITS) - 16'd1);

    logic [CLK_DIV_BITS-1:0] presc_q, presc_d;
    logic [2:0]              idx_q, idx_d;
    logic [31:0]             sh_hex_q, sh_hex_d;
    logic [7:0]              sh_pt_q, sh_pt_d;
    logic [7:0]              sh_le_q, sh_le_d;
    logic                    frame_done_q, frame_done_d;
    logic                    tick;
    logic                    wrap;
    logic [7:0]              le_force;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q      <= '0;
            idx_q        <= '0;
            sh_hex_q     <= '0;
            sh_pt_q      <= '0;
            sh_le_q      <= 8'hFF;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            sh_hex_q     <= sh_hex_d;
            sh_pt_q      <= sh_pt_d;
            sh_le_q      <= sh_le_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        tick         = en && (&presc_q);
        wrap         = tick && (idx_q == LAST_IDX);
        presc_d      = presc_q;
        idx_d        = idx_q;
        sh_hex_d     = sh_hex_q;
        sh_pt_d      = sh_pt_q;
        sh_le_d      = sh_le_q;
        frame_done_d = wrap;
        if (en) begin
            presc_d = presc_q + 1'b1;
        end
        if (tick) begin
            idx_d = wrap ? 3'd0 : idx_q + 3'd1;
        end
        // Capture only at the frame boundary so a frame never mixes old and new data.
        if (wrap && !freeze) begin
            sh_hex_d = hexs;
            sh_pt_d  = points;
            sh_le_d  = LEs;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lzb
            if (gi == 0 || gi >= N_DIGITS) begin : g_never
                assign le_force[gi] = 1'b0;
            end else begin : g_check
                // Blank when this digit and everything to its left is a plain zero.
                assign le_force[gi] = (sh_hex_q[4*N_DIGITS-1:4*gi] == '0) &&
                                      (sh_pt_q[N_DIGITS-1:gi] == '0);
            end
        end
    endgenerate
`else
    assign le_force = '0;
`endif

    always_comb begin
        D          = sh_hex_q[{idx_q, 2'b00} +: 4];
        point      = sh_pt_q[idx_q];
        LE         = sh_le_q[idx_q] | le_force[idx_q];
        AN         = en ? (~(8'd1 << idx_q) | ~USED_AN) : 8'hFF;
        frame_done = frame_done_q;
    end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl with CLK_DIV_BITS=2, N_DIGITS=8 (32-clock frame).
module tb_sseg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        freeze;
    logic [31:0] hexs;
    logic [7:0]  points;
    logic [7:0]  LEs;
    logic [3:0]  D;
    logic        point;
    logic        LE;
    logic [7:0]  AN;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;   // enabled clock edges since reset release

    sseg_scan_ctrl #(.CLK_DIV_BITS(2), .N_DIGITS(8)) dut (
        .clk(clk), .rst(rst), .en(en), .freeze(freeze),
        .hexs(hexs), .points(points), .LEs(LEs),
        .D(D), .point(point), .LE(LE), .AN(AN), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
        cyc += n;
    endtask

    // Advance to the first cycle of the given slot (at least one clock).
    task automatic goto_slot(input int s);
        do adv(1); while ((cyc % 32) != s * 4);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; freeze = 1'b0;
        hexs = 32'h89ABCDEF; points = 8'h01; LEs = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_AN", AN, 8'hFE);
        chk("rst_LE", LE, 1'b1);
        chk("rst_D", D, 4'h0);
        chk("rst_fd", frame_done, 1'b0);
        en = 1'b0; #1;
        chk("rst_AN_dark", AN, 8'hFF);
        en = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Frame 0: anode walk, shadow still blank
        for (int s = 0; s < 8; s++) begin
            chk($sformatf("walk_AN%0d", s), AN, ~(32'd1 << s) & 32'hFF);
            if (s < 7) adv(4);
        end
        chk("frame0_LE", LE, 1'b1);
        adv(3);
        chk("fd_before", frame_done, 1'b0);
        adv(1);
        chk("fd_pulse", frame_done, 1'b1);
        chk("wrap_AN", AN, 8'hFE);
        adv(1);
        chk("fd_drop", frame_done, 1'b0);

        // Frame 1: 89ABCDEF captured
        chk("f1_d0_D", D, 4'hF);
        chk("f1_d0_pt", point, 1'b1);
        chk("f1_d0_LE", LE, 1'b0);
        goto_slot(3);
        chk("f1_d3_D", D, 4'hC);
        hexs = 32'h12345678;
        adv(1);
        chk("f1_d3_D_hold", D, 4'hC);
        goto_slot(7);
        chk("f1_d7_D", D, 4'h8);
        chk("f1_d7_pt", point, 1'b0);
        chk("f1_d7_LE", LE, 1'b0);

        // Frame 2: new data from digit 0
        goto_slot(0);
        chk("f2_d0_D", D, 4'h8);
        chk("f2_d0_pt", point, 1'b1);
        goto_slot(3);
        chk("f2_d3_D", D, 4'h5);
        goto_slot(7);
        chk("f2_d7_D", D, 4'h1);

        // Freeze across a boundary
        hexs = 32'hAAAAAAAA; freeze = 1'b1;
        goto_slot(0);
        chk("frz_fd", frame_done, 1'b1);
        chk("frz_d0_D", D, 4'h8);
        freeze = 1'b0;
        goto_slot(7);
        chk("frz_d7_D", D, 4'h1);
        goto_slot(0);
        chk("unfrz_fd", frame_done, 1'b1);
        chk("unfrz_d0_D", D, 4'hA);

        // Pause at idx=5, prescaler=2
        goto_slot(5);
        adv(2);
        chk("pause_AN_pre", AN, 8'hDF);
        en = 1'b0;
        #1;
        chk("pause_AN_dark", AN, 8'hFF);
        repeat (10) @(negedge clk);
        chk("pause_AN_dark10", AN, 8'hFF);
        chk("pause_D_hold", D, 4'hA);
        en = 1'b1;
        #1;
        chk("resume_AN", AN, 8'hDF);
        adv(1);
        chk("resume_AN_1", AN, 8'hDF);
        adv(1);
        chk("resume_AN_2", AN, 8'hBF);

        // Leading-zero handling
        hexs = 32'h00000120; points = 8'h00; LEs = 8'h00;
        goto_slot(0);
        for (int s = 0; s < 8; s++) begin
`ifdef LEADING_ZERO_BLANK_EN
            chk($sformatf("lz_LE%0d", s), LE, (s >= 3) ? 1'b1 : 1'b0);
`else
            chk($sformatf("lz_LE%0d", s), LE, 1'b0);
`endif
            if (s < 7) adv(4);
        end
        hexs = 32'h00000000;
        goto_slot(0);
        chk("zero_d0_D", D, 4'h0);
        chk("zero_d0_LE", LE, 1'b0);
        adv(4);
`ifdef LEADING_ZERO_BLANK_EN
        chk("zero_d1_LE", LE, 1'b1);
`else
        chk("zero_d1_LE", LE, 1'b0);
`endif

        // Mid-frame reset blanks shadow immediately
        goto_slot(4);
        rst = 1'b1;
        #1;
        chk("mrst_AN", AN, 8'hFE);
        chk("mrst_LE", LE, 1'b1);
        chk("mrst_D", D, 4'h0);
        @(negedge clk);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
